// File: rtl/opb_simulink2opb_master.sv
// Single-beat OPB master: turns a user command/response handshake into one OPB
// transfer, handling arbitration, slave retry, timeout and error reporting.
module opb_simulink2opb_master #(
    parameter int C_OPB_AWIDTH  = 32,
    parameter int C_OPB_DWIDTH  = 32,
    parameter int C_TOUT_CYCLES = 16,
    parameter int C_MAX_RETRY   = 3
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rnw,
    input  logic [C_OPB_AWIDTH-1:0]     cmd_addr,
    input  logic [C_OPB_DWIDTH-1:0]     cmd_wdata,
    input  logic [C_OPB_DWIDTH/8-1:0]   cmd_be,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [C_OPB_DWIDTH-1:0]     rsp_rdata,
    output logic                        rsp_err,
    output logic                        rsp_tout,
    output logic                        M_request,
    input  logic                        OPB_MGrant,
    output logic                        M_select,
    output logic                        M_RNW,
    output logic [0:C_OPB_AWIDTH-1]     M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
    output logic [0:C_OPB_DWIDTH-1]     M_DBus,
    output logic                        M_seqAddr,
    output logic                        M_busLock,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_xferAck,
    input  logic                        OPB_errAck,
    input  logic                        OPB_retry,
    input  logic                        OPB_toutSup,
    output logic [1:0]                  dbg_state_o
);
    localparam int TW = (C_TOUT_CYCLES > 1) ? $clog2(C_TOUT_CYCLES) : 1;
    localparam int RW = $clog2(C_MAX_RETRY + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_RESP} state_t;

    state_t                      state_q;
    logic                        rnw_q;
    logic [C_OPB_AWIDTH-1:0]     addr_q;
    logic [C_OPB_DWIDTH-1:0]     wdata_q;
    logic [C_OPB_DWIDTH/8-1:0]   be_q;
    logic [RW-1:0]               retry_q;
    logic [TW-1:0]               tout_q;
    logic                        cmd_ready_q, m_request_q, m_select_q;
    logic                        rsp_valid_q, rsp_err_q, rsp_tout_q;
    logic [C_OPB_DWIDTH-1:0]     rsp_rdata_q;

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst) begin
            state_q     <= ST_IDLE;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            retry_q     <= '0;
            tout_q      <= '0;
            cmd_ready_q <= 1'b1;
            m_request_q <= 1'b0;
            m_select_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tout_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        rnw_q       <= cmd_rnw;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        be_q        <= cmd_be;
                        retry_q     <= '0;
                        cmd_ready_q <= 1'b0;
                        m_request_q <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (OPB_MGrant) begin
                        m_request_q <= 1'b0;
                        m_select_q  <= 1'b1;
                        tout_q      <= '0;
                        state_q     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // errAck outranks xferAck, so a simultaneous pair reports an error.
                    if (OPB_errAck) begin
                        m_select_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (OPB_xferAck) begin
                        m_select_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rnw_q ? OPB_DBus : '0;
                        state_q     <= ST_RESP;
                    end else if (OPB_retry) begin
                        m_select_q <= 1'b0;
                        if (retry_q < RW'(C_MAX_RETRY)) begin
                            retry_q     <= retry_q + 1'b1;
                            m_request_q <= 1'b1;
                            state_q     <= ST_REQ;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end else if (!OPB_toutSup) begin
                        if (tout_q == TW'(C_TOUT_CYCLES - 1)) begin
                            m_select_q  <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_tout_q  <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            tout_q <= tout_q + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_tout_q  <= 1'b0;
                        rsp_rdata_q <= '0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_tout    = rsp_tout_q;
    assign M_request   = m_request_q;
    assign M_select    = m_select_q;
    // OR-bus: everything is forced to 0 while not selected; plain assignment keeps MSB alignment.
    assign M_RNW       = m_select_q & rnw_q;
    assign M_ABus      = m_select_q ? addr_q : '0;
    assign M_BE        = m_select_q ? be_q : '0;
    assign M_DBus      = (m_select_q && !rnw_q) ? wdata_q : '0;
    assign M_seqAddr   = 1'b0;
    assign M_busLock   = 1'b0;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_opb_simulink2opb_master.sv
// Bench for opb_simulink2opb_master: plays arbiter and slave, predicts each
// response from the bus rules and checks bus behaviour cycle by cycle.
module tb_opb_simulink2opb_master;
    localparam int TOUT = 16;
    localparam int MAXR = 3;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_tout;
    logic [31:0] rsp_rdata;
    logic        M_request, OPB_MGrant, M_select, M_RNW, M_seqAddr, M_busLock;
    logic [0:31] M_ABus, M_DBus, OPB_DBus;
    logic [0:3]  M_BE;
    logic        OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    opb_simulink2opb_master dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_tout(rsp_tout),
        .M_request(M_request), .OPB_MGrant(OPB_MGrant), .M_select(M_select),
        .M_RNW(M_RNW), .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
        .M_seqAddr(M_seqAddr), .M_busLock(M_busLock),
        .OPB_DBus(OPB_DBus), .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
        .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup),
        .dbg_state_o(dbg_state)
    );

    // clock / watchdog
    always #5 OPB_Clk = ~OPB_Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle(input string tag);
        check({tag, "_sel"},  M_select, 0);
        check({tag, "_rnw"},  M_RNW, 0);
        check({tag, "_abus"}, M_ABus, 0);
        check({tag, "_be"},   M_BE, 0);
        check({tag, "_dbus"}, M_DBus, 0);
        check({tag, "_seq"},  {M_seqAddr, M_busLock}, 0);
    endtask

    // garbage on the command port while busy must be ignored
    task automatic scramble();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_rnw   = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_be    = 4'($urandom);
    endtask

    task automatic slave_quiet();
        OPB_xferAck = 1'b0;
        OPB_errAck  = 1'b0;
        OPB_retry   = 1'b0;
        OPB_toutSup = 1'b0;
        OPB_DBus    = '0;
    endtask

    // kind: 0 no response, 1 xferAck, 2 errAck, 3 both; r = select cycle of the
    // response; s = leading selected cycles with toutSup high; n_ret retries first.
    task automatic run_txn(input bit rnw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] rdata, input int gnt_dly,
                           input int n_ret, input int kind, input int r, input int s,
                           input int rsp_dly);
        bit exp_err, exp_tout, done;
        logic [31:0] exp_rd;
        int retries, r_att, s_att, k_att, end_j;
        // reference model: timeout fires on the TOUT-th unsuppressed selected cycle
        if (n_ret > MAXR) begin
            exp_err  = 1'b1;
            exp_tout = 1'b0;
        end else begin
            exp_tout = !(kind != 0 && r >= 1 && r <= s + TOUT);
            exp_err  = !exp_tout && (kind >= 2);
        end
        exp_q.push_back((rnw && !exp_err && !exp_tout) ? rdata : 32'h0);

        check("idle_ready", cmd_ready, 1);
        check("idle_req", M_request, 0);
        bus_idle("pre");
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
        @(negedge OPB_Clk);
        scramble();
        retries = 0;
        done = 1'b0;
        while (!done) begin
            for (int g = 0; g < gnt_dly; g++) begin
                check("req_wait", M_request, 1);
                check("req_nosel", M_select, 0);
                check("busy_ready", cmd_ready, 0);
                @(negedge OPB_Clk);
                scramble();
            end
            check("req_grant", M_request, 1);
            OPB_MGrant = 1'b1;
            @(negedge OPB_Clk);
            OPB_MGrant = 1'b0;
            scramble();
            if (retries < n_ret) begin
                k_att = 4; r_att = $urandom_range(1, 4); s_att = 0;
            end else begin
                k_att = kind; r_att = r; s_att = s;
            end
            end_j = (k_att != 0 && r_att >= 1 && r_att <= s_att + TOUT) ? r_att : s_att + TOUT;
            for (int j = 1; j <= end_j; j++) begin
                check("sel", M_select, 1);
                check("sel_req", M_request, 0);
                check("sel_rnw", M_RNW, rnw);
                check("sel_abus", M_ABus, addr);
                check("sel_be", M_BE, be);
                if (!rnw) check("sel_dbus", M_DBus, wdata);
                OPB_toutSup = (j <= s_att);
                OPB_DBus    = $urandom;
                if (j == r_att) begin
                    case (k_att)
                        1: begin OPB_xferAck = 1'b1; OPB_DBus = rdata; end
                        2: OPB_errAck = 1'b1;
                        3: begin OPB_xferAck = 1'b1; OPB_errAck = 1'b1; OPB_DBus = rdata; end
                        4: OPB_retry = 1'b1;
                        default: ;
                    endcase
                end
                @(negedge OPB_Clk);
                slave_quiet();
                scramble();
            end
            if (k_att == 4) begin
                retries++;
                if (retries <= MAXR) check("retry_drop", M_select, 0);
                else done = 1'b1;
            end else begin
                done = 1'b1;
            end
        end

        bus_idle("post");
        check("post_req", M_request, 0);
        exp_rd = exp_q.pop_front();
        for (int h = 0; h <= rsp_dly; h++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_rdata", rsp_rdata, exp_rd);
            check("rsp_err", rsp_err, exp_err);
            check("rsp_tout", rsp_tout, exp_tout);
            check("rsp_busy_ready", cmd_ready, 0);
            if (h < rsp_dly) begin
                @(negedge OPB_Clk);
                scramble();
            end
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge OPB_Clk);
        rsp_ready = 1'b0;
        check("done_valid", rsp_valid, 0);
        check("done_ready", cmd_ready, 1);
        check("done_fields", {rsp_rdata, rsp_err, rsp_tout}, 0);
    endtask

    initial begin
        OPB_Rst = 1'b0;
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
        rsp_ready = 1'b0;
        OPB_MGrant = 1'b0;
        slave_quiet();
        repeat (3) @(negedge OPB_Clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_req", M_request, 0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_tout}, 0);
        check("rst_rdata", rsp_rdata, 0);
        bus_idle("rst");
        OPB_Rst = 1'b1;
        @(negedge OPB_Clk);

        // directed steps
        run_txn(0, 32'h0108F700, 32'hDEADBEEF, 4'hF, 32'hA5A5A5A5, 2, 0, 1, 1, 0, 0);
        run_txn(1, 32'h0108F704, 32'h0, 4'hF, 32'h12345678, 0, 0, 1, 3, 0, 0);
        run_txn(1, 32'h00000010, 32'h0, 4'h3, 32'hCAFEF00D, 1, 2, 1, 1, 0, 1);
        run_txn(0, 32'h00000020, 32'h11112222, 4'hC, 32'h0, 0, 4, 1, 1, 0, 0);
        run_txn(1, 32'h00000030, 32'h0, 4'hF, 32'h55AA55AA, 0, 0, 0, 0, 0, 0);
        run_txn(1, 32'h00000034, 32'h0, 4'hF, 32'h0BADC0DE, 0, 0, 1, 41, 40, 0);
        run_txn(1, 32'h00000038, 32'h0, 4'hF, 32'h77778888, 0, 0, 3, 2, 0, 10);

        // reset in the middle of a transfer
        check("mid_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h0000ABC0; cmd_be = 4'hF;
        @(negedge OPB_Clk);
        cmd_valid = 1'b0;
        OPB_MGrant = 1'b1;
        @(negedge OPB_Clk);
        OPB_MGrant = 1'b0;
        check("mid_sel", M_select, 1);
        OPB_Rst = 1'b0;
        @(negedge OPB_Clk);
        OPB_Rst = 1'b1;
        bus_idle("mid_rst");
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_req", M_request, 0);
        @(negedge OPB_Clk);
        check("mid_rst_valid2", rsp_valid, 0);
        run_txn(0, 32'h0108F700, 32'h01234567, 4'h1, 32'h0, 0, 0, 1, 2, 0, 0);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            int n_ret, kind, r, s;
            n_ret = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            kind  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
            r     = $urandom_range(1, 20);
            s     = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), $urandom,
                    $urandom_range(0, 3), n_ret, kind, r, s, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
